// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory controller: default depth, controller
// states and the byte-lane merge used to rebuild a stored word.
package dm_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 4096;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_e;

  // Lanes with a set enable come from new_word, the rest keep old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (byteen[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous word RAM, one byte-wide array per lane, with
// read-first registered output (a write returns the previous word).
module dm_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem_q [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        lane_rd_q <= lane_mem_q[addr];
        if (we[gi]) lane_mem_q[addr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_rd_q;
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: CPU word accesses with byte enables, store trace,
// out-of-range reporting and a zero-fill sweep after reset or on request.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = DEPTH_WORDS_DEFAULT,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteen,
  output logic        req_ready,
  input  logic        clr_start,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        wlog_valid,
  output logic [31:0] wlog_addr,
  output logic [31:0] wlog_data,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dm_state_e     state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rd_hit_q, rd_hit_d;
  logic          err_q, err_d;
  logic          wlog_valid_q, wlog_valid_d;
  logic [31:0]   wlog_addr_q, wlog_addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    byteen_q, byteen_d;
  logic [31:0]   rsp_hold_q, rsp_hold_d;
  logic [31:0]   wlog_hold_q, wlog_hold_d;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic accept;
  logic is_read;
  logic in_range;
  logic last_word;

  assign req_ready = (state_q == READY) & ~clr_start;
  assign busy      = (state_q == CLEAR);
  assign accept    = req_valid & req_ready;
  assign is_read   = (req_byteen == 4'b0000);
  assign in_range  = ({2'b00, req_addr[31:2]} < DEPTH_WORDS);
  assign last_word = (clr_cnt_q == AW'(DEPTH_WORDS - 1));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = req_addr[AW+1:2];
    ram_wdata = req_wdata;

    if (state_q == CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 4'b1111;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
      if (clr_start) begin
        clr_cnt_d = '0;
      end else if (last_word) begin
        state_d   = READY;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end else begin
      if (clr_start) begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end else if (accept && in_range) begin
        ram_en = 1'b1;
        ram_we = req_byteen;
      end
    end
  end

  always_comb begin
    rsp_valid_d  = accept & is_read;
    rd_hit_d     = accept & is_read & in_range;
    err_d        = accept & ~in_range;
    wlog_valid_d = accept & ~is_read & in_range;
    wlog_addr_d  = wlog_valid_d ? {req_addr[31:2], 2'b00} : wlog_addr_q;
    wdata_d      = wlog_valid_d ? req_wdata : wdata_q;
    byteen_d     = wlog_valid_d ? req_byteen : byteen_q;
    rsp_hold_d   = rsp_rdata;
    wlog_hold_d  = wlog_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLR_ON_RESET ? CLEAR : READY;
      clr_cnt_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rd_hit_q     <= 1'b0;
      err_q        <= 1'b0;
      wlog_valid_q <= 1'b0;
      wlog_addr_q  <= '0;
      wdata_q      <= '0;
      byteen_q     <= '0;
      rsp_hold_q   <= '0;
      wlog_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rd_hit_q     <= rd_hit_d;
      err_q        <= err_d;
      wlog_valid_q <= wlog_valid_d;
      wlog_addr_q  <= wlog_addr_d;
      wdata_q      <= wdata_d;
      byteen_q     <= byteen_d;
      rsp_hold_q   <= rsp_hold_d;
      wlog_hold_q  <= wlog_hold_d;
    end
  end

  dm_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register also moves on stores and sweeps, so responses are
  // taken from it only in the pulse cycle and held locally otherwise.
  assign rsp_valid  = rsp_valid_q;
  assign err        = err_q;
  assign wlog_valid = wlog_valid_q;
  assign wlog_addr  = wlog_addr_q;
  assign rsp_rdata  = rd_hit_q ? ram_rdata : (rsp_valid_q ? 32'h0 : rsp_hold_q);
  assign wlog_data  = wlog_valid_q ? merge_lanes(ram_rdata, wdata_q, byteen_q)
                                   : wlog_hold_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl with a 16-word memory and a word-array model.
module tb_dm_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_byteen = '0;
  logic        clr_start = 1'b0;
  logic        req_ready, rsp_valid, err, wlog_valid, busy;
  logic [31:0] rsp_rdata, wlog_addr, wlog_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];

  dm_ctrl #(.DEPTH_WORDS(DEPTH), .CLR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byteen(req_byteen), .req_ready(req_ready),
    .clr_start(clr_start), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err(err), .wlog_valid(wlog_valid), .wlog_addr(wlog_addr),
    .wlog_data(wlog_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    req_valid  = v;
    req_addr   = a;
    req_wdata  = d;
    req_byteen = be;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    clr_start = 1'b0;
  endtask

  function automatic logic [31:0] model_store(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, n, DEPTH);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_after: got %b required 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({busy, req_ready, rsp_valid, err, wlog_valid} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got busy/rdy/rsp/err/wlog=%b required 10000",
               {busy, req_ready, rsp_valid, err, wlog_valid});
    end
    checks++;
    if ({rsp_rdata, wlog_addr, wlog_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h waddr=%h wdata=%h required zeros",
               rsp_rdata, wlog_addr, wlog_data);
    end
    reset = 1'b1;
    model_clear();
    wait_sweep("reset");
    $display("txn reset release: sweep done");
  endtask

  task automatic test_sweep_reads();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 4), 32'h0, 4'h0);
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL sweep_read_%0d: got valid=%b data=%h required 1/00000000",
                 i, rsp_valid, rsp_rdata);
      end
      $display("txn read word %0d -> %h", i, rsp_rdata);
    end
    idle();
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_rsp_pulse: got %b required 0", rsp_valid);
    end
  endtask

  task automatic test_merge();
    drive(1'b1, 32'h8, 32'hAABBCCDD, 4'b1111);
    step();
    model_mem[2] = model_store(model_mem[2], 32'hAABBCCDD, 4'b1111);
    checks++;
    if (wlog_valid !== 1'b1 || wlog_addr !== 32'h8 || wlog_data !== model_mem[2]) begin
      errors++;
      $display("FAIL merge_wlog1: got v=%b a=%h d=%h required 1/00000008/%h",
               wlog_valid, wlog_addr, wlog_data, model_mem[2]);
    end
    drive(1'b1, 32'h9, 32'h00001100, 4'b0010);
    step();
    model_mem[2] = model_store(model_mem[2], 32'h00001100, 4'b0010);
    checks++;
    if (wlog_valid !== 1'b1 || wlog_addr !== 32'h8 || wlog_data !== 32'hAABB11DD) begin
      errors++;
      $display("FAIL merge_wlog2: got v=%b a=%h d=%h required 1/00000008/aabb11dd",
               wlog_valid, wlog_addr, wlog_data);
    end
    drive(1'b1, 32'h8, 32'h0, 4'h0);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[2]) begin
      errors++;
      $display("FAIL merge_read: got v=%b d=%h required 1/%h", rsp_valid, rsp_rdata,
               model_mem[2]);
    end
    $display("txn merge word 2 -> %h", rsp_rdata);
    idle();
    step();
    checks++;
    if (rsp_rdata !== model_mem[2] || wlog_valid !== 1'b0) begin
      errors++;
      $display("FAIL merge_hold: got d=%h wlog=%b required %h/0", rsp_rdata, wlog_valid,
               model_mem[2]);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h4, 32'h12345678, 4'hF);
    step();
    model_mem[1] = 32'h12345678;
    drive(1'b1, 32'h4, 32'h0, 4'h0);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_read: got v=%b d=%h required 1/12345678", rsp_valid, rsp_rdata);
    end
    $display("txn back-to-back word 1 -> %h", rsp_rdata);
    idle();
    step();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 32'(DEPTH * 4), 32'h0, 4'h0);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: got v=%b d=%h err=%b required 1/00000000/1",
               rsp_valid, rsp_rdata, err);
    end
    drive(1'b1, 32'(DEPTH * 4), 32'hDEADBEEF, 4'hF);
    step();
    checks++;
    if (err !== 1'b1 || wlog_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: got err=%b wlog=%b rsp=%b required 1/0/0",
               err, wlog_valid, rsp_valid);
    end
    drive(1'b1, 32'h0, 32'h0, 4'h0);
    step();
    checks++;
    if (rsp_rdata !== model_mem[0] || err !== 1'b0) begin
      errors++;
      $display("FAIL oor_mem_unchanged: got d=%h err=%b required %h/0", rsp_rdata, err,
               model_mem[0]);
    end
    $display("txn out-of-range read/write, word 0 -> %h", rsp_rdata);
    idle();
    step();
  endtask

  task automatic test_clr_collision();
    drive(1'b1, 32'hC, 32'hFFFFFFFF, 4'hF);
    clr_start = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %b required 0", req_ready);
    end
    step();
    idle();
    checks++;
    if (busy !== 1'b1 || wlog_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_accept: got busy=%b wlog=%b err=%b required 1/0/0",
               busy, wlog_valid, err);
    end
    model_clear();
    wait_sweep("clr");
    for (int w = 1; w <= 3; w++) begin
      drive(1'b1, 32'(w * 4), 32'h0, 4'h0);
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[w]) begin
        errors++;
        $display("FAIL clr_read_%0d: got v=%b d=%h required 1/%h", w, rsp_valid,
                 rsp_rdata, model_mem[w]);
      end
      $display("txn after clear word %0d -> %h", w, rsp_rdata);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_sweep();
    drive(1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
    step();
    drive(1'b1, 32'h14, 32'h0, 4'h0);
    step();
    idle();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (busy !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || wlog_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL midsweep_hold: got busy=%b d=%h wd=%h required 1/cafef00d/cafef00d",
               busy, rsp_rdata, wlog_data);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, err, wlog_valid, req_ready} !== 4'b0000 ||
        {rsp_rdata, wlog_addr, wlog_data} !== 96'h0) begin
      errors++;
      $display("FAIL midsweep_reset: got flags=%b d=%h a=%h wd=%h required zeros",
               {rsp_valid, err, wlog_valid, req_ready}, rsp_rdata, wlog_addr, wlog_data);
    end
    step();
    step();
    reset = 1'b1;
    model_clear();
    wait_sweep("midsweep");
    drive(1'b1, 32'h14, 32'h0, 4'h0);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[5]) begin
      errors++;
      $display("FAIL midsweep_read: got v=%b d=%h required 1/%h", rsp_valid, rsp_rdata,
               model_mem[5]);
    end
    $display("txn reset mid-sweep, word 5 -> %h", rsp_rdata);
    idle();
    step();
  endtask

  task automatic test_random();
    logic [31:0] last_rdata;
    last_rdata = 32'h0;
    for (int t = 0; t < 80; t++) begin
      logic        v, exp_rsp, exp_err, exp_wlog;
      logic [31:0] a, d, exp_rdata, exp_waddr, exp_wdata;
      logic [3:0]  be;
      int          idx;
      idx = $urandom_range(0, DEPTH + 3);
      a   = 32'(idx * 4 + $urandom_range(0, 3));
      d   = $urandom;
      v   = ($urandom_range(0, 3) != 0);
      be  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      exp_rsp = 1'b0; exp_err = 1'b0; exp_wlog = 1'b0;
      exp_rdata = last_rdata; exp_waddr = 32'h0; exp_wdata = 32'h0;
      if (v) begin
        if (idx >= DEPTH) begin
          exp_err = 1'b1;
          if (be == 4'h0) begin
            exp_rsp = 1'b1;
            exp_rdata = 32'h0;
          end
        end else if (be == 4'h0) begin
          exp_rsp = 1'b1;
          exp_rdata = model_mem[idx];
        end else begin
          model_mem[idx] = model_store(model_mem[idx], d, be);
          exp_wlog = 1'b1;
          exp_waddr = 32'(idx * 4);
          exp_wdata = model_mem[idx];
        end
      end
      drive(v, a, d, be);
      step();
      last_rdata = exp_rdata;
      checks++;
      if ({rsp_valid, err, wlog_valid} !== {exp_rsp, exp_err, exp_wlog}) begin
        errors++;
        $display("FAIL rand_%0d_pulses: got rsp/err/wlog=%b required %b", t,
                 {rsp_valid, err, wlog_valid}, {exp_rsp, exp_err, exp_wlog});
      end
      checks++;
      if (rsp_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rand_%0d_rdata: got %h required %h", t, rsp_rdata, exp_rdata);
      end
      if (exp_wlog) begin
        checks++;
        if (wlog_addr !== exp_waddr || wlog_data !== exp_wdata) begin
          errors++;
          $display("FAIL rand_%0d_wlog: got a=%h d=%h required %h/%h", t, wlog_addr,
                   wlog_data, exp_waddr, exp_wdata);
        end
      end
      $display("txn %0d v=%b addr=%h be=%h wdata=%h -> rsp=%b rdata=%h err=%b wlog=%b",
               t, v, a, be, d, rsp_valid, rsp_rdata, err, wlog_valid);
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_sweep_reads();
    test_merge();
    test_back_to_back();
    test_out_of_range();
    test_clr_collision();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, is the number of 32-bit words of data memory.
REQ-002 Parameter CLR_ON_RESET, default 1; when 1, a zero-fill sweep runs after reset release.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU data access request this cycle.
REQ-006 req_addr  input  32  byte address; bits [1:0] ignored, word index = req_addr>>2.
REQ-007 req_wdata  input  32  store data, byte lanes aligned to the word.
REQ-008 req_byteen  input  4  byte-lane write enables; 4'b0000 means read.
REQ-009 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-010 clr_start  input  1  one-cycle pulse that starts a software zero-fill sweep.
REQ-011 rsp_valid  output  1  read data valid pulse.
REQ-012 rsp_rdata  output  32  read data.
REQ-013 err  output  1  one-cycle pulse for an out-of-range access.
REQ-014 wlog_valid, wlog_addr[31:0], wlog_data[31:0]  outputs  store trace: word-aligned address and merged word written.
REQ-015 busy  output  1  high while a zero-fill sweep is in progress.

Function
REQ-016 States: CLEAR and READY; req_ready = (state==READY) & ~clr_start.
REQ-017 CLEAR: write 0 to word clr_cnt each cycle, clr_cnt counting 0..DEPTH_WORDS-1; after the last word, go to READY next cycle; busy=1 throughout CLEAR.
REQ-018 READY + clr_start: go to CLEAR with clr_cnt=0; no request is accepted in that cycle.
REQ-019 A clr_start pulse during CLEAR restarts the sweep at word 0.
REQ-020 Read (accepted, byteen==0, in range): rsp_valid=1 and rsp_rdata=mem[idx] in the following cycle; latency is exactly 1 cycle.
REQ-021 Write (accepted, byteen!=0, in range): for each set bit k, write lane k (bits 8k+7:8k) from req_wdata; other lanes are unchanged; the word is updated at the accepting edge.
REQ-022 Write: in the following cycle, wlog_valid=1, wlog_addr=req_addr&32'hFFFFFFFC, and wlog_data=the full merged word.
REQ-023 Read of a word written in the immediately preceding accepted cycle returns the new merged value.
REQ-024 Out of range (idx >= DEPTH_WORDS): writes are dropped with no wlog; reads give rsp_valid=1 with rsp_rdata=0; err=1 in the following cycle in both cases.
REQ-025 rsp_valid, wlog_valid and err are single-cycle pulses and are low when no request was accepted in the previous cycle.
REQ-026 rsp_rdata holds its last value between pulses.

Reset
REQ-027 While reset=0: state=CLEAR if CLR_ON_RESET else READY; clr_cnt=0; rsp_valid, wlog_valid and err are 0; rsp_rdata, wlog_addr and wlog_data are 0.
REQ-028 Asserting reset mid-sweep or mid-access aborts the operation; the sweep restarts at word 0 after release.
REQ-029 Memory contents are not reset asynchronously; the sweep alone zeroes them.

Structure
REQ-030 Package dm_pkg holds DEPTH_WORDS default, the state enum {CLEAR, READY} and the lane-merge function.
REQ-031 Sub-module dm_ram is a single-port synchronous word RAM with 4-bit byte-write enable and registered read; dm_ctrl instantiates one.

Verification
REQ-032 Release reset with DEPTH_WORDS=16 -> busy high for 16 cycles, then req_ready=1; reads of all 16 words return 0.
REQ-033 Write addr 0x8, data 0xAABBCCDD, byteen 4'b1111, then write addr 0x9, data 0x00001100, byteen 4'b0010 -> wlog_data=0xAABB11DD; a read of 0x8 returns 0xAABB11DD one cycle later.
REQ-034 Back-to-back write 0x4 <= 0x12345678 then read 0x4 on the next cycle -> rsp_rdata=0x12345678.
REQ-035 Read at idx=DEPTH_WORDS, then write at the same address -> rsp_rdata=0 with err=1, then err=1 with no wlog_valid; memory is unchanged.
REQ-036 clr_start together with req_valid in READY -> request not accepted; after the sweep, earlier-written words read as 0.
REQ-037 Reset asserted at clr_cnt=5 -> all outputs go to 0 immediately; after release the sweep restarts from 0 and busy lasts the full DEPTH_WORDS cycles.
